// File: rtl/pcie_tx.sv
// pcie_tx: builds posted MWr (3DW, optional 4DW) and 1-DW CplD TLPs on a 64-bit AXI stream.
// Define PCIE_TX_ADDR64_EN to emit 4DW MWr when the upper address half is non-zero.

module pcie_tx_chk #(
  parameter int MAX_QW = 16
) (
  input logic       clock,
  input logic       reset,
  input logic       wr_valid,
  input logic       wr_ready,
  input logic [9:0] wr_qwords
);
  // flag write requests longer than the supported payload size
  always_ff @(posedge clock) begin
    if (!reset && wr_valid && wr_ready) begin
      assert (wr_qwords <= 10'(MAX_QW));
    end
  end
endmodule

module pcie_tx #(
  parameter int MAX_QW = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pcie_id,
  input  logic        rr_valid,
  output logic        rr_ready,
  input  logic [31:0] rr_rc_dw2,
  input  logic [31:0] rr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [63:0] wr_addr,
  input  logic [9:0]  wr_qwords,
  input  logic [63:0] wr_data,
  output logic        wr_data_ren,
  input  logic        tready,
  output logic        tvalid,
  output logic        tlast,
  output logic [7:0]  tkeep,
  output logic [63:0] tdata
);
  typedef enum logic [2:0] {IDLE, CPL0, CPL1, WR_H0, WR_H1, WR_D, WR_END} state_t;

  function automatic logic [31:0] es(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  state_t      state_q, state_d;
  logic        tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [7:0]  tkeep_q, tkeep_d;
  logic [63:0] tdata_q, tdata_d;
  logic [31:0] cpl_dw2_q, cpl_dw2_d, cpl_data_q, cpl_data_d;
  logic [31:0] addr_lo_q, addr_lo_d, carry_q, carry_d;
  logic [9:0]  rem_q, rem_d;
  logic        load_s, ren_s, wr_acc_s, is64_s, new64_s;
  logic [31:0] addr_hi_s, dw0_s;
  logic [9:0]  qw_s, len_s;

  assign rr_ready    = !reset && (state_q == IDLE);
  assign wr_ready    = rr_ready && !rr_valid;
  assign wr_acc_s    = wr_valid && wr_ready;
  assign load_s      = !tvalid_q || tready;
  assign wr_data_ren = ren_s && !reset;
  assign tvalid      = tvalid_q;
  assign tlast       = tlast_q;
  assign tkeep       = tkeep_q;
  assign tdata       = tdata_q;

`ifdef PCIE_TX_ADDR64_EN
  logic        is64_q, is64_d;
  logic [31:0] addr_hi_q, addr_hi_d;

  assign new64_s   = (wr_addr[63:32] != 32'h0);
  assign is64_s    = is64_q;
  assign addr_hi_s = addr_hi_q;

  // addressing mode is latched with every accepted write request
  always_comb begin
    if (wr_acc_s) begin
      is64_d    = new64_s;
      addr_hi_d = wr_addr[63:32];
    end else begin
      is64_d    = is64_q;
      addr_hi_d = addr_hi_q;
    end
  end

  // 4DW address state
  always_ff @(posedge clock) begin
    if (reset) begin
      is64_q    <= 1'b0;
      addr_hi_q <= 32'h0;
    end else begin
      is64_q    <= is64_d;
      addr_hi_q <= addr_hi_d;
    end
  end
`else
  logic unused_addr_hi_s;
  assign unused_addr_hi_s = ^wr_addr[63:32];
  assign new64_s   = 1'b0;
  assign is64_s    = 1'b0;
  assign addr_hi_s = 32'h0;
`endif

  // oversize requests are clipped; length field counts DWs
  always_comb begin
    qw_s  = (wr_qwords > 10'(MAX_QW)) ? 10'(MAX_QW) : wr_qwords;
    len_s = {qw_s[8:0], 1'b0};
    dw0_s = (new64_s ? 32'h6000_0000 : 32'h4000_0000) | {22'h0, len_s};
  end

  // next state and next output beat
  always_comb begin
    state_d    = state_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tkeep_d    = tkeep_q;
    tdata_d    = tdata_q;
    cpl_dw2_d  = cpl_dw2_q;
    cpl_data_d = cpl_data_q;
    addr_lo_d  = addr_lo_q;
    carry_d    = carry_q;
    rem_d      = rem_q;
    ren_s      = 1'b0;
    if (tvalid_q && tready) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end else begin
      tvalid_d = tvalid_q;
    end
    case (state_q)
      IDLE: begin
        if (rr_valid) begin
          cpl_dw2_d  = rr_rc_dw2;
          cpl_data_d = rr_data;
          tvalid_d   = 1'b1;
          tlast_d    = 1'b0;
          tkeep_d    = 8'hFF;
          tdata_d    = {pcie_id, 16'h0004, 32'h4A00_0001};
          state_d    = CPL0;
        end else if (wr_valid && (qw_s != 10'd0)) begin
          addr_lo_d = wr_addr[31:0];
          rem_d     = qw_s;
          tvalid_d  = 1'b1;
          tlast_d   = 1'b0;
          tkeep_d   = 8'hFF;
          tdata_d   = {pcie_id, 8'h00, 8'hFF, dw0_s};
          state_d   = WR_H0;
        end else begin
          state_d = IDLE;
        end
      end
      CPL0: begin
        if (load_s) begin
          tvalid_d = 1'b1;
          tlast_d  = 1'b1;
          tkeep_d  = 8'hFF;
          tdata_d  = {es(cpl_data_q), cpl_dw2_q};
          state_d  = CPL1;
        end else begin
          state_d = CPL0;
        end
      end
      WR_H0: begin
        if (load_s) begin
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          tkeep_d  = 8'hFF;
          state_d  = WR_H1;
          if (is64_s) begin
            tdata_d = {addr_lo_q, addr_hi_s};
          end else begin
            tdata_d = {es(wr_data[31:0]), addr_lo_q};
            carry_d = es(wr_data[63:32]);
            rem_d   = rem_q - 10'd1;
            ren_s   = 1'b1;
          end
        end else begin
          state_d = WR_H0;
        end
      end
      WR_H1, WR_D: begin
        if (load_s) begin
          tvalid_d = 1'b1;
          if (is64_s) begin
            // 4DW payload is qword aligned: one full qword per beat
            tdata_d = {es(wr_data[63:32]), es(wr_data[31:0])};
            tkeep_d = 8'hFF;
            tlast_d = (rem_q == 10'd1);
            rem_d   = rem_q - 10'd1;
            ren_s   = 1'b1;
            state_d = (rem_q == 10'd1) ? WR_END : WR_D;
          end else if (rem_q != 10'd0) begin
            tdata_d = {es(wr_data[31:0]), carry_q};
            carry_d = es(wr_data[63:32]);
            tkeep_d = 8'hFF;
            tlast_d = 1'b0;
            rem_d   = rem_q - 10'd1;
            ren_s   = 1'b1;
            state_d = WR_D;
          end else begin
            tdata_d = {32'h0, carry_q};
            tkeep_d = 8'h0F;
            tlast_d = 1'b1;
            state_d = WR_END;
          end
        end else begin
          state_d = state_q;
        end
      end
      CPL1, WR_END: begin
        if (tvalid_q && tready) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d  = IDLE;
        tvalid_d = 1'b0;
      end
    endcase
  end

  // state and output stage; reset aborts any TLP in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tkeep_q    <= 8'h00;
      tdata_q    <= 64'h0;
      cpl_dw2_q  <= 32'h0;
      cpl_data_q <= 32'h0;
      addr_lo_q  <= 32'h0;
      carry_q    <= 32'h0;
      rem_q      <= 10'd0;
    end else begin
      state_q    <= state_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tkeep_q    <= tkeep_d;
      tdata_q    <= tdata_d;
      cpl_dw2_q  <= cpl_dw2_d;
      cpl_data_q <= cpl_data_d;
      addr_lo_q  <= addr_lo_d;
      carry_q    <= carry_d;
      rem_q      <= rem_d;
    end
  end

  pcie_tx_chk #(.MAX_QW(MAX_QW)) u_chk (
    .clock    (clock),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_qwords(wr_qwords)
  );
endmodule

// File: tb/tb_pcie_tx.sv
// tb_pcie_tx: directed self-checking bench for pcie_tx (CplD, 3DW/4DW MWr, stalls, reset abort).
`timescale 1ns/1ps
module tb_pcie_tx;
  typedef logic [72:0] beat_t;  // {tlast, tkeep, tdata}

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] pcie_id;
  logic        rr_valid, rr_ready;
  logic [31:0] rr_rc_dw2, rr_data;
  logic        wr_valid, wr_ready;
  logic [63:0] wr_addr;
  logic [9:0]  wr_qwords;
  logic [63:0] wr_data;
  logic        wr_data_ren;
  logic        tready, tvalid, tlast;
  logic [7:0]  tkeep;
  logic [63:0] tdata;

  logic [63:0] fifo_mem [0:255];
  logic [7:0]  fifo_idx = 8'd0;
  logic        ren_n = 1'b0;
  logic [63:0] qbuf [0:15];

  beat_t beats[$];
  int    beat_cyc[$];
  int    cyc = 0;
  int    ren_cnt = 0;
  int    stall_err = 0;
  logic  stall_prev = 1'b0;
  beat_t held = '0;
  int    n_tests = 0;
  int    n_fail = 0;

  assign wr_data = fifo_mem[fifo_idx];

  pcie_tx #(.MAX_QW(16)) dut (
    .clock(clock), .reset(reset), .pcie_id(pcie_id),
    .rr_valid(rr_valid), .rr_ready(rr_ready), .rr_rc_dw2(rr_rc_dw2), .rr_data(rr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_qwords(wr_qwords),
    .wr_data(wr_data), .wr_data_ren(wr_data_ren),
    .tready(tready), .tvalid(tvalid), .tlast(tlast), .tkeep(tkeep), .tdata(tdata)
  );

  always #5 clock = ~clock;

  // cycle counter and FWFT FIFO read pointer
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (ren_n) fifo_idx <= fifo_idx + 8'd1;
  end

  // stream monitor: handshaken beats, ren pulses, stall stability
  always @(negedge clock) begin
    ren_n <= wr_data_ren;
    if (wr_data_ren) ren_cnt <= ren_cnt + 1;
    if (stall_prev && (!tvalid || ({tlast, tkeep, tdata} !== held))) stall_err <= stall_err + 1;
    stall_prev <= tvalid && !tready && !reset;
    held <= {tlast, tkeep, tdata};
    if (tvalid && tready) begin
      beats.push_back({tlast, tkeep, tdata});
      beat_cyc.push_back(cyc);
    end
  end

  function automatic logic [31:0] es(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // expected 3DW MWr beat i for n qwords held in qbuf
  function automatic beat_t exp3(input int i, input int n, input logic [31:0] a);
    logic [9:0] len;
    len = 10'(2 * n);
    if (i == 0) return {1'b0, 8'hFF, 16'h0100, 8'h00, 8'hFF, 32'h4000_0000 | {22'h0, len}};
    else if (i == 1) return {1'b0, 8'hFF, es(qbuf[0][31:0]), a};
    else if (i <= n) return {1'b0, 8'hFF, es(qbuf[i-1][31:0]), es(qbuf[i-2][63:32])};
    else return {1'b1, 8'h0F, 32'h0, es(qbuf[n-1][63:32])};
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic accept_rr();
    int k;
    for (k = 0; k < 200; k++) begin
      if (rr_ready) break;
      tick();
    end
    chk("rr_accept", 80'(k < 200), 80'd1);
    tick();
    rr_valid = 1'b0;
  endtask

  task automatic accept_wr();
    int k;
    for (k = 0; k < 200; k++) begin
      if (wr_ready) break;
      tick();
    end
    chk("wr_accept", 80'(k < 200), 80'd1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_beats(input int base, input int k, input bit stall);
    int c;
    for (c = 0; c < 3000; c++) begin
      if (beats.size() - base >= k) break;
      tick();
      if (stall) tready = 1'($urandom_range(0, 1));
    end
    tready = 1'b1;
    chk("beat_wait", 80'(beats.size() - base >= k), 80'd1);
  endtask

  task automatic load_fifo(input int n);
    for (int i = 0; i < n; i++) fifo_mem[fifo_idx + 8'(i)] = qbuf[i];
  endtask

  initial begin
    int base, ren0, st0;
    logic [63:0] addr3;
    reset = 1'b1; pcie_id = 16'h0100; tready = 1'b1;
    rr_valid = 1'b0; rr_rc_dw2 = 32'h0; rr_data = 32'h0;
    wr_valid = 1'b0; wr_addr = 64'h0; wr_qwords = 10'd0;
    repeat (3) tick();
    chk("reset_outputs", {3'b0, tvalid, tlast, tkeep, tdata, wr_data_ren, rr_ready, wr_ready}, 80'h0);
    reset = 1'b0;
    tick();
    chk("idle_ready", 80'({rr_ready, wr_ready}), 80'b11);

    // 1: CplD
    base = beats.size();
    rr_rc_dw2 = 32'h1234_5608; rr_data = 32'hAABB_CCDD; rr_valid = 1'b1;
    accept_rr();
    rr_data = 32'h0;
    chk("cpl_latency", 80'(tvalid), 80'd1);
    wait_beats(base, 2, 1'b0);
    chk("cpl_beat0", 80'(beats[base]),     80'({1'b0, 8'hFF, 64'h0100_0004_4A00_0001}));
    chk("cpl_beat1", 80'(beats[base + 1]), 80'({1'b1, 8'hFF, 64'hDDCC_BBAA_1234_5608}));
    repeat (3) tick();

    // 2: 3DW MWr, n=2
    base = beats.size(); ren0 = ren_cnt;
    qbuf[0] = 64'h0706_0504_0302_0100; qbuf[1] = 64'h0F0E_0D0C_0B0A_0908;
    load_fifo(2);
    wr_addr = 64'h1000; wr_qwords = 10'd2; wr_valid = 1'b1;
    accept_wr();
    wait_beats(base, 4, 1'b0);
    repeat (3) tick();
    chk("mwr2_beat0", 80'(beats[base]),     80'({1'b0, 8'hFF, 64'h0100_00FF_4000_0004}));
    chk("mwr2_beat1", 80'(beats[base + 1]), 80'({1'b0, 8'hFF, 64'h0001_0203_0000_1000}));
    chk("mwr2_beat2", 80'(beats[base + 2]), 80'({1'b0, 8'hFF, 64'h0809_0A0B_0405_0607}));
    chk("mwr2_beat3", 80'(beats[base + 3]), 80'({1'b1, 8'h0F, 64'h0000_0000_0C0D_0E0F}));
    chk("mwr2_nbeats", 80'(beats.size() - base), 80'd4);
    chk("mwr2_ren", 80'(ren_cnt - ren0), 80'd2);

    // zero-length write: accepted and dropped
    base = beats.size(); ren0 = ren_cnt;
    wr_qwords = 10'd0; wr_valid = 1'b1;
    accept_wr();
    repeat (6) tick();
    chk("zero_nbeats", 80'(beats.size() - base), 80'd0);
    chk("zero_ren", 80'(ren_cnt - ren0), 80'd0);
    chk("zero_idle", 80'({tvalid, rr_ready}), 80'b01);

    // 3: CplD and MWr requested together
    base = beats.size();
    qbuf[0] = 64'h8877_6655_4433_2211;
    load_fifo(1);
    rr_rc_dw2 = 32'h0000_0004; rr_data = 32'h0102_0304; rr_valid = 1'b1;
    wr_addr = 64'h40; wr_qwords = 10'd1; wr_valid = 1'b1;
    #1;
    chk("tie_ready", 80'({rr_ready, wr_ready}), 80'b10);
    accept_rr();
    accept_wr();
    wait_beats(base, 5, 1'b0);
    chk("tie_cpl1",  80'(beats[base + 1]), 80'({1'b1, 8'hFF, 64'h0403_0201_0000_0004}));
    chk("tie_mwr0",  80'(beats[base + 2]), 80'({1'b0, 8'hFF, 64'h0100_00FF_4000_0002}));
    chk("tie_mwr1",  80'(beats[base + 3]), 80'({1'b0, 8'hFF, 64'h1122_3344_0000_0040}));
    chk("tie_mwr2",  80'(beats[base + 4]), 80'({1'b1, 8'h0F, 64'h0000_0000_5566_7788}));
    chk("tie_bubble", 80'(beat_cyc[base + 2] - beat_cyc[base + 1]), 80'd2);
    repeat (3) tick();

    // 4: n=MAX_QW with random back-pressure
    base = beats.size(); ren0 = ren_cnt; st0 = stall_err;
    for (int i = 0; i < 16; i++) qbuf[i] = {$urandom, $urandom};
    load_fifo(16);
    wr_addr = 64'h8000; wr_qwords = 10'd16; wr_valid = 1'b1;
    accept_wr();
    wait_beats(base, 18, 1'b1);
    repeat (4) tick();
    for (int i = 0; i < 18; i++) chk($sformatf("stall_beat%0d", i), 80'(beats[base + i]), 80'(exp3(i, 16, 32'h8000)));
    chk("stall_nbeats", 80'(beats.size() - base), 80'd18);
    chk("stall_ren", 80'(ren_cnt - ren0), 80'd16);
    chk("stall_stable", 80'(stall_err - st0), 80'd0);

    // 5: reset while beat 2 of an n=4 MWr is on the bus
    base = beats.size(); ren0 = ren_cnt;
    qbuf[0] = 64'h1111_2222_3333_4444; qbuf[1] = 64'h5555_6666_7777_8888;
    qbuf[2] = 64'h9999_AAAA_BBBB_CCCC; qbuf[3] = 64'hDDDD_EEEE_FFFF_0000;
    load_fifo(4);
    wr_addr = 64'h100; wr_qwords = 10'd4; wr_valid = 1'b1;
    accept_wr();
    wait_beats(base, 2, 1'b0);
    reset = 1'b1;
    tick();
    chk("abort_outputs", 80'({tvalid, rr_ready, wr_data_ren}), 80'b000);
    reset = 1'b0;
    tick();
    chk("abort_idle", 80'({tvalid, rr_ready}), 80'b01);
    repeat (3) tick();
    chk("abort_beat2", 80'(beats[base + 2]), 80'(exp3(2, 4, 32'h100)));
    chk("abort_nbeats", 80'(beats.size() - base), 80'd3);
    chk("abort_ren", 80'(ren_cnt - ren0), 80'd2);
    base = beats.size();
    rr_rc_dw2 = 32'hBEEF_0010; rr_data = 32'h1122_3344; rr_valid = 1'b1;
    accept_rr();
    wait_beats(base, 2, 1'b0);
    chk("post_cpl0", 80'(beats[base]),     80'({1'b0, 8'hFF, 64'h0100_0004_4A00_0001}));
    chk("post_cpl1", 80'(beats[base + 1]), 80'({1'b1, 8'hFF, 64'h4433_2211_BEEF_0010}));
    repeat (3) tick();

    // 6: 64-bit addressing
    qbuf[0] = 64'h0706_0504_0302_0100;
`ifdef PCIE_TX_ADDR64_EN
    base = beats.size(); ren0 = ren_cnt;
    load_fifo(1);
    wr_addr = 64'h1_0000_2000; wr_qwords = 10'd1; wr_valid = 1'b1;
    accept_wr();
    wait_beats(base, 3, 1'b0);
    repeat (3) tick();
    chk("a64_beat0", 80'(beats[base]),     80'({1'b0, 8'hFF, 64'h0100_00FF_6000_0002}));
    chk("a64_beat1", 80'(beats[base + 1]), 80'({1'b0, 8'hFF, 64'h0000_2000_0000_0001}));
    chk("a64_beat2", 80'(beats[base + 2]), 80'({1'b1, 8'hFF, 64'h0405_0607_0001_0203}));
    chk("a64_ren", 80'(ren_cnt - ren0), 80'd1);
    addr3 = 64'h0000_0000_0000_2000;
`else
    addr3 = 64'h0000_0001_0000_2000;
`endif
    base = beats.size(); ren0 = ren_cnt;
    load_fifo(1);
    wr_addr = addr3; wr_qwords = 10'd1; wr_valid = 1'b1;
    accept_wr();
    wait_beats(base, 3, 1'b0);
    repeat (3) tick();
    chk("a32_beat0", 80'(beats[base]),     80'({1'b0, 8'hFF, 64'h0100_00FF_4000_0002}));
    chk("a32_beat1", 80'(beats[base + 1]), 80'({1'b0, 8'hFF, 64'h0001_0203_0000_2000}));
    chk("a32_beat2", 80'(beats[base + 2]), 80'({1'b1, 8'h0F, 64'h0000_0000_0405_0607}));
    chk("a32_nbeats", 80'(beats.size() - base), 80'd3);
    chk("a32_ren", 80'(ren_cnt - ren0), 80'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
